// File: rtl/mem_resp_pkg.sv
// Shared bus widths, parameter defaults and common types for the mem_resp slave.
package mem_resp_pkg;

    localparam int DATA_W              = 32;
    localparam int ADDR_W              = 32;
    localparam int BE_W                = DATA_W / 8;

    localparam int MEM_WORDS_DEF       = 1024;
    localparam int RD_LATENCY_DEF      = 2;
    localparam int WAIT_STATES_DEF     = 0;
    localparam int MAX_OUTSTANDING_DEF = 2;

    // Wide enough for WAIT_STATES up to 7 and MAX_OUTSTANDING up to 4.
    localparam int CNT_W               = 3;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [BE_W-1:0]   be_t;

endpackage

// File: rtl/mem_resp_if.sv
// Request/acknowledge bus between a master and the mem_resp memory slave.
interface mem_resp_if;
    import mem_resp_pkg::*;

    logic  req;
    logic  we;
    addr_t addr;
    be_t   be;
    word_t wdata;
    logic  ack;
    logic  resp;
    word_t rdata;

    modport master (output req, we, addr, be, wdata, input ack, resp, rdata);
    modport slave  (input req, we, addr, be, wdata, output ack, resp, rdata);

endinterface

// File: rtl/mem_resp_pipe.sv
// Fixed-depth valid/data shift pipeline; stage 0 doubles as the memory read register.
module mem_resp_pipe
    import mem_resp_pkg::*;
#(
    parameter int DEPTH = RD_LATENCY_DEF
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  in_valid,
    input  word_t in_data,
    output logic  out_valid,
    output word_t out_data
);

    logic  valid_reg [DEPTH];
    word_t data_reg  [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic  valid_in;
            word_t data_in;

            if (gi == 0) begin : g_head
                assign valid_in = in_valid;
                assign data_in  = in_data;
            end else begin : g_tail
                assign valid_in = valid_reg[gi-1];
                assign data_in  = data_reg[gi-1];
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    valid_reg[gi] <= 1'b0;
                    data_reg[gi]  <= '0;
                end else begin
                    valid_reg[gi] <= valid_in;
                    data_reg[gi]  <= data_in;
                end
            end
        end
    endgenerate

    assign out_valid = valid_reg[DEPTH-1];
    assign out_data  = data_reg[DEPTH-1];

endmodule

// File: rtl/mem_resp.sv
// Word-addressed memory slave with wait states, byte-enabled writes and
// in-order pipelined reads with a bounded number of outstanding requests.
module mem_resp
    import mem_resp_pkg::*;
#(
    parameter int MEM_WORDS       = MEM_WORDS_DEF,
    parameter int RD_LATENCY      = RD_LATENCY_DEF,
    parameter int WAIT_STATES     = WAIT_STATES_DEF,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
    input logic       clk_i,
    input logic       rst_i,
    mem_resp_if.slave bus
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    word_t            mem [MEM_WORDS];
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] wait_reg, wait_next;
    logic [CNT_W-1:0] outstanding_reg, outstanding_next;
    logic             rd_fire, wr_fire;
    logic             pipe_valid;
    word_t            pipe_data;

    // Upper address bits and the byte offset are deliberately dropped so accesses wrap.
    assign idx = bus.addr[IDX_W+1:2];
    wire unused_addr = ^{bus.addr[ADDR_W-1:IDX_W+2], bus.addr[1:0]};

    assign bus.ack = bus.req && !rst_i
                  && (wait_reg == CNT_W'(WAIT_STATES))
                  && (bus.we || (outstanding_reg < CNT_W'(MAX_OUTSTANDING)));
    assign rd_fire = bus.ack && !bus.we;
    assign wr_fire = bus.ack && bus.we;

    always_comb begin
        wait_next = wait_reg;
        if (!bus.req || bus.ack) begin
            wait_next = '0;
        end else if (wait_reg != CNT_W'(WAIT_STATES)) begin
            wait_next = wait_reg + 1'b1;
        end
    end

    always_comb begin
        outstanding_next = outstanding_reg;
        case ({rd_fire, pipe_valid})
            2'b10:   outstanding_next = outstanding_reg + 1'b1;
            2'b01:   outstanding_next = outstanding_reg - 1'b1;
            default: outstanding_next = outstanding_reg;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_reg        <= '0;
            outstanding_reg <= '0;
        end else begin
            wait_reg        <= wait_next;
            outstanding_reg <= outstanding_next;
        end
    end

    // Storage is never reset; only enabled byte lanes are written.
    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            for (int i = 0; i < BE_W; i++) begin
                if (bus.be[i]) begin
                    mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    mem_resp_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_pipe (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .in_valid  (rd_fire),
        .in_data   (mem[idx]),
        .out_valid (pipe_valid),
        .out_data  (pipe_data)
    );

    assign bus.resp  = pipe_valid;
    assign bus.rdata = pipe_valid ? pipe_data : '0;

endmodule
